// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - byte-serial RAM/IO port controller arbitrating data and fetch requests
//
// Purpose: sole owner of the byte-wide RAM/IO port. Accepts one data request
// (load/store of 1/2/4 bytes) or one instruction fetch (4 bytes) at a time,
// walks it byte by byte, and returns an assembled 32-bit result with a
// one-cycle done pulse. Data requests win over fetches.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global enable, 0 = hold all)
//   mem_clear          pipeline flush
//   io_buffer_full     UART buffer full; blocks stores to the IO ports
//   mem_din/mem_dout   RAM read/write byte
//   mem_a, mem_wr      RAM byte address and write strobe
//   lsb_request, lsb_load_or_store, lsb_op, lsb_addr, lsb_data  data request
//   lsb_mem_valid, lsb_mem_val   data done pulse and extended load result
//   if_request, if_addr          fetch request
//   if_valid, if_data            fetch done pulse and instruction word
//
// lsb_op encoding: Lb=1 Lh=2 Lw=3 Lbu=4 Lhu=5 Sb=6 Sh=7 Sw=8.

module mem_controller #(
    parameter int unsigned RAM_LAT  = 2,
    parameter logic [31:0] IO_ADDR0 = 32'h0003_0000,
    parameter logic [31:0] IO_ADDR1 = 32'h0003_0004
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        mem_clear,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        lsb_request,
    input  logic        lsb_load_or_store,
    input  logic [5:0]  lsb_op,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_data,
    output logic        lsb_mem_valid,
    output logic [31:0] lsb_mem_val,
    input  logic        if_request,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_data
);

    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;

    localparam logic [7:0] LAT8 = 8'(RAM_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_FETCH,
        S_COOL
    } state_t;

    function automatic logic [7:0] size_of(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) begin
            return 8'd1;
        end else if (op == OP_LH || op == OP_LHU || op == OP_SH) begin
            return 8'd2;
        end else begin
            return 8'd4;
        end
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [5:0] op);
        case (op)
            OP_LB:   return {{24{v[7]}}, v[7:0]};
            OP_LH:   return {{16{v[15]}}, v[15:0]};
            OP_LBU:  return {24'd0, v[7:0]};
            OP_LHU:  return {16'd0, v[15:0]};
            default: return v;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;       // index of the edge being processed, relative to acceptance
    logic [7:0]  n_q, n_d;           // number of bytes in the access
    logic [31:0] base_q, base_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] buf_q, buf_d;       // bytes captured so far
    logic        drop_q, drop_d;     // flush seen during a store: complete silently
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic        mem_wr_q, mem_wr_d;
    logic        lsb_valid_q, lsb_valid_d;
    logic [31:0] lsb_val_q, lsb_val_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_data_q, if_data_d;

    logic        io_blocked;
    logic [7:0]  cap_idx;
    logic [31:0] asm_word;
    logic [31:0] sdata_shift;

    assign io_blocked = lsb_load_or_store && io_buffer_full &&
                        (lsb_addr == IO_ADDR0 || lsb_addr == IO_ADDR1);

    // The byte arriving on mem_din now belongs to the address driven RAM_LAT edges ago.
    assign cap_idx     = cnt_q - LAT8;
    assign sdata_shift = sdata_q >> {cnt_q[1:0], 3'b000};

    always_comb begin
        asm_word = buf_q;
        for (int k = 0; k < 4; k++) begin
            if (cap_idx == 8'(k)) begin
                asm_word[8*k +: 8] = mem_din;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        base_d      = base_q;
        op_d        = op_q;
        sdata_d     = sdata_q;
        buf_d       = buf_q;
        drop_d      = drop_q;
        mem_dout_d  = mem_dout_q;
        mem_a_d     = mem_a_q;
        mem_wr_d    = mem_wr_q;
        lsb_valid_d = 1'b0;
        lsb_val_d   = lsb_val_q;
        if_valid_d  = 1'b0;
        if_data_d   = if_data_q;

        case (state_q)
            S_IDLE: begin
                if (!mem_clear) begin
                    if (lsb_request) begin
                        // A blocked IO store stays pending and still shadows the fetch.
                        if (!io_blocked) begin
                            base_d  = lsb_addr;
                            op_d    = lsb_op;
                            n_d     = size_of(lsb_op);
                            cnt_d   = 8'd1;
                            buf_d   = 32'd0;
                            drop_d  = 1'b0;
                            mem_a_d = lsb_addr;
                            if (lsb_load_or_store) begin
                                sdata_d    = lsb_data;
                                mem_dout_d = lsb_data[7:0];
                                mem_wr_d   = 1'b1;
                                state_d    = S_STORE;
                            end else begin
                                mem_wr_d = 1'b0;
                                state_d  = S_LOAD;
                            end
                        end
                    end else if (if_request) begin
                        base_d   = if_addr;
                        n_d      = 8'd4;
                        cnt_d    = 8'd1;
                        buf_d    = 32'd0;
                        mem_a_d  = if_addr;
                        mem_wr_d = 1'b0;
                        state_d  = S_FETCH;
                    end
                end
            end

            S_LOAD, S_FETCH: begin
                mem_wr_d = 1'b0;
                if (mem_clear) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q < n_q) begin
                        mem_a_d = base_q + 32'(cnt_q);
                    end
                    if (cnt_q >= LAT8) begin
                        buf_d = asm_word;
                    end
                    if (cnt_q == n_q + LAT8 - 8'd1) begin
                        state_d = S_COOL;
                        if (state_q == S_LOAD) begin
                            lsb_valid_d = 1'b1;
                            lsb_val_d   = extend(asm_word, op_q);
                        end else begin
                            if_valid_d = 1'b1;
                            if_data_d  = asm_word;
                        end
                    end
                end
            end

            S_STORE: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_clear) begin
                    drop_d = 1'b1;
                end
                if (cnt_q < n_q) begin
                    mem_a_d    = base_q + 32'(cnt_q);
                    mem_dout_d = sdata_shift[7:0];
                    mem_wr_d   = 1'b1;
                end else begin
                    mem_wr_d    = 1'b0;
                    lsb_valid_d = !(drop_q || mem_clear);
                    state_d     = S_COOL;
                end
            end

            // Requesters drop their level one edge after the pulse; skip that edge.
            S_COOL: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            n_q         <= 8'd0;
            base_q      <= 32'd0;
            op_q        <= 6'd0;
            sdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            drop_q      <= 1'b0;
            mem_dout_q  <= 8'd0;
            mem_a_q     <= 32'd0;
            mem_wr_q    <= 1'b0;
            lsb_valid_q <= 1'b0;
            lsb_val_q   <= 32'd0;
            if_valid_q  <= 1'b0;
            if_data_q   <= 32'd0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            base_q      <= base_d;
            op_q        <= op_d;
            sdata_q     <= sdata_d;
            buf_q       <= buf_d;
            drop_q      <= drop_d;
            mem_dout_q  <= mem_dout_d;
            mem_a_q     <= mem_a_d;
            mem_wr_q    <= mem_wr_d;
            lsb_valid_q <= lsb_valid_d;
            lsb_val_q   <= lsb_val_d;
            if_valid_q  <= if_valid_d;
            if_data_q   <= if_data_d;
        end
    end

    assign mem_dout      = mem_dout_q;
    assign mem_a         = mem_a_q;
    assign mem_wr        = mem_wr_q;
    assign lsb_mem_valid = lsb_valid_q;
    assign lsb_mem_val   = lsb_val_q;
    assign if_valid      = if_valid_q;
    assign if_data       = if_data_q;

endmodule

// File: tb/tb_mem_controller.sv
// tb/tb_mem_controller.sv - directed self-checking bench for mem_controller

module tb_mem_controller;

    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        mem_clear = 1'b0;
    logic        io_full = 1'b0;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        lsb_request = 1'b0;
    logic        lsb_ls = 1'b0;
    logic [5:0]  lsb_op = 6'd0;
    logic [31:0] lsb_addr = 32'd0;
    logic [31:0] lsb_data = 32'd0;
    logic        lsb_mem_valid;
    logic [31:0] lsb_mem_val;
    logic        if_request = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_valid;
    logic [31:0] if_data;

    logic [7:0]  ram  [0:65535];
    logic [7:0]  wram [0:65535];

    int checks = 0;
    int failures = 0;

    mem_controller dut (
        .clk_in            (clk),
        .rst_in            (rst_n),
        .rdy_in            (rdy),
        .mem_clear         (mem_clear),
        .io_buffer_full    (io_full),
        .mem_din           (mem_din),
        .mem_dout          (mem_dout),
        .mem_a             (mem_a),
        .mem_wr            (mem_wr),
        .lsb_request       (lsb_request),
        .lsb_load_or_store (lsb_ls),
        .lsb_op            (lsb_op),
        .lsb_addr          (lsb_addr),
        .lsb_data          (lsb_data),
        .lsb_mem_valid     (lsb_mem_valid),
        .lsb_mem_val       (lsb_mem_val),
        .if_request        (if_request),
        .if_addr           (if_addr),
        .if_valid          (if_valid),
        .if_data           (if_data)
    );

    always #5 clk = ~clk;

    // RAM with two-edge read latency: address seen at edge k is on mem_din for edge k+2.
    always @(posedge clk) begin
        mem_din <= ram[mem_a[15:0]];
        if (mem_wr) wram[mem_a[15:0]] <= mem_dout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a read, check address sweep and a single done pulse at edge n+1.
    task automatic run_read(input string tag, input bit fetch, input logic [5:0] op,
                            input logic [31:0] addr, input int n, input logic [31:0] exp);
        if (fetch) begin
            if_request = 1'b1;
            if_addr    = addr;
        end else begin
            lsb_request = 1'b1;
            lsb_ls      = 1'b0;
            lsb_op      = op;
            lsb_addr    = addr;
        end
        for (int e = 0; e <= n; e++) begin
            tick();
            if (e < n) chk({tag, "_addr"}, mem_a, addr + 32'(e));
            chk({tag, "_wr"}, 32'(mem_wr), 32'd0);
            chk({tag, "_early"}, {30'd0, lsb_mem_valid, if_valid}, 32'd0);
        end
        tick();
        if (fetch) begin
            chk({tag, "_pulse"}, {30'd0, lsb_mem_valid, if_valid}, 32'd1);
            chk({tag, "_data"}, if_data, exp);
        end else begin
            chk({tag, "_pulse"}, {30'd0, lsb_mem_valid, if_valid}, 32'd2);
            chk({tag, "_data"}, lsb_mem_val, exp);
        end
        tick();
        chk({tag, "_one_cycle"}, {30'd0, lsb_mem_valid, if_valid}, 32'd0);
        lsb_request = 1'b0;
        if_request  = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1000] = 8'h11; ram[16'h1001] = 8'h22;
        ram[16'h1002] = 8'h33; ram[16'h1003] = 8'h44;
        ram[16'h1010] = 8'h80;
        ram[16'h2001] = 8'hFE; ram[16'h2002] = 8'hFF;
        ram[16'h0100] = 8'h13;

        // Reset state
        tick();
        tick();
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_lsb_valid", 32'(lsb_mem_valid), 32'd0);
        chk("rst_lsb_val", lsb_mem_val, 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        rst_n = 1'b1;
        tick();

        // Lw, then no re-issue while the request lingers into COOL
        run_read("lw", 1'b0, OP_LW, 32'h1000, 4, 32'h4433_2211);
        chk("lw_no_reissue", mem_a, 32'h1003);

        // Extension and misaligned halfword
        run_read("lb", 1'b0, OP_LB, 32'h1010, 1, 32'hFFFF_FF80);
        run_read("lbu", 1'b0, OP_LBU, 32'h1010, 1, 32'h0000_0080);
        run_read("lh_mis", 1'b0, OP_LH, 32'h2001, 2, 32'hFFFF_FFFE);

        // Sh
        lsb_request = 1'b1; lsb_ls = 1'b1; lsb_op = OP_SH;
        lsb_addr = 32'h3000; lsb_data = 32'hABCD_1234;
        tick();
        chk("sh_e0", {mem_a[23:0], mem_dout}, {24'h003000, 8'h34});
        chk("sh_e0_wr", 32'(mem_wr), 32'd1);
        tick();
        chk("sh_e1", {mem_a[23:0], mem_dout}, {24'h003001, 8'h12});
        chk("sh_e1_wr", 32'(mem_wr), 32'd1);
        tick();
        chk("sh_e2_wr", 32'(mem_wr), 32'd0);
        chk("sh_e2_pulse", 32'(lsb_mem_valid), 32'd1);
        tick();
        chk("sh_e3_pulse", 32'(lsb_mem_valid), 32'd0);
        lsb_request = 1'b0;
        tick();
        chk("sh_ram", {wram[16'h3001], wram[16'h3000]}, 32'h0000_1234);

        // rdy_in low holds everything mid-store
        lsb_request = 1'b1; lsb_ls = 1'b1; lsb_op = OP_SB;
        lsb_addr = 32'h3100; lsb_data = 32'h0000_0077;
        tick();
        chk("rdy_e0_wr", 32'(mem_wr), 32'd1);
        rdy = 1'b0;
        tick();
        tick();
        chk("rdy_hold_wr", 32'(mem_wr), 32'd1);
        chk("rdy_hold_a", mem_a, 32'h3100);
        chk("rdy_hold_pulse", 32'(lsb_mem_valid), 32'd0);
        rdy = 1'b1;
        tick();
        chk("rdy_done_wr", 32'(mem_wr), 32'd0);
        chk("rdy_done_pulse", 32'(lsb_mem_valid), 32'd1);
        tick();
        lsb_request = 1'b0;
        tick();

        // Data request wins, fetch follows after COOL
        lsb_request = 1'b1; lsb_ls = 1'b0; lsb_op = OP_LW; lsb_addr = 32'h1000;
        if_request = 1'b1; if_addr = 32'h0100;
        tick();
        chk("arb_data_first", mem_a, 32'h1000);
        repeat (4) tick();
        tick();
        chk("arb_lsb_pulse", {30'd0, lsb_mem_valid, if_valid}, 32'd2);
        chk("arb_lsb_val", lsb_mem_val, 32'h4433_2211);
        tick();
        chk("arb_cool_no_fetch", mem_a, 32'h1003);
        lsb_request = 1'b0;
        tick();
        chk("arb_fetch_start", mem_a, 32'h0100);
        repeat (4) tick();
        tick();
        chk("arb_if_pulse", {30'd0, lsb_mem_valid, if_valid}, 32'd1);
        chk("arb_if_data", if_data, 32'h0000_0013);
        tick();
        chk("arb_if_one_cycle", 32'(if_valid), 32'd0);
        if_request = 1'b0;
        tick();

        // IO store blocked by full buffer; fetch must not slip past it
        lsb_request = 1'b1; lsb_ls = 1'b1; lsb_op = OP_SB;
        lsb_addr = 32'h0003_0000; lsb_data = 32'h0000_005A;
        if_request = 1'b1; if_addr = 32'h0100;
        io_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("io_blocked_wr", {30'd0, mem_wr, if_valid}, 32'd0);
        end
        chk("io_blocked_no_fetch", mem_a, 32'h0103);
        io_full = 1'b0;
        tick();
        chk("io_write_a", mem_a, 32'h0003_0000);
        chk("io_write", {23'd0, mem_wr, mem_dout}, {23'd0, 1'b1, 8'h5A});
        tick();
        chk("io_done", {30'd0, mem_wr, lsb_mem_valid}, 32'd1);
        tick();
        lsb_request = 1'b0;

        // Fetch aborted by mem_clear at its edge 3
        tick();
        chk("clr_fetch_e0", mem_a, 32'h0100);
        tick();
        tick();
        chk("clr_fetch_e2", mem_a, 32'h0102);
        mem_clear = 1'b1;
        tick();
        chk("clr_fetch_e3", {30'd0, mem_wr, if_valid}, 32'd0);
        mem_clear = 1'b0;
        if_request = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("clr_fetch_no_pulse", {30'd0, mem_wr, if_valid}, 32'd0);
        end
        chk("clr_fetch_data_kept", if_data, 32'h0000_0013);

        // mem_clear in IDLE blocks acceptance
        mem_clear = 1'b1;
        lsb_request = 1'b1; lsb_ls = 1'b0; lsb_op = OP_LW; lsb_addr = 32'h1000;
        tick();
        chk("clr_idle_no_accept", mem_a, 32'h0102);
        mem_clear = 1'b0;
        lsb_request = 1'b0;
        tick();

        // Sw with mem_clear at edge 1: all bytes written, no pulse
        lsb_request = 1'b1; lsb_ls = 1'b1; lsb_op = OP_SW;
        lsb_addr = 32'h4000; lsb_data = 32'hDEAD_BEEF;
        tick();
        chk("sw_clr_e0", {mem_a[23:0], mem_dout}, {24'h004000, 8'hEF});
        mem_clear = 1'b1;
        tick();
        chk("sw_clr_e1", {mem_a[23:0], mem_dout}, {24'h004001, 8'hBE});
        mem_clear = 1'b0;
        lsb_request = 1'b0;
        tick();
        tick();
        chk("sw_clr_e3", {7'd0, mem_wr, mem_a[23:0]}, {7'd0, 1'b1, 24'h004003});
        tick();
        chk("sw_clr_e4", {30'd0, mem_wr, lsb_mem_valid}, 32'd0);
        tick();
        chk("sw_clr_e5", 32'(lsb_mem_valid), 32'd0);
        chk("sw_clr_ram", {wram[16'h4003], wram[16'h4002], wram[16'h4001], wram[16'h4000]},
            32'hDEAD_BEEF);

        // Reset in the middle of a store
        lsb_request = 1'b1; lsb_ls = 1'b1; lsb_op = OP_SW;
        lsb_addr = 32'h5000; lsb_data = 32'h0102_0304;
        tick();
        tick();
        chk("rst_mid_wr_before", 32'(mem_wr), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr", 32'(mem_wr), 32'd0);
        chk("rst_mid_a", mem_a, 32'd0);
        lsb_request = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_mid_idle_wr", 32'(mem_wr), 32'd0);
        run_read("lb_after_rst", 1'b0, OP_LB, 32'h1010, 1, 32'hFFFF_FF80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
